// File: rtl/mem_read_slave.sv
// mem_read_slave: single-outstanding AXI-style read responder over a backdoor-preloaded 64-bit word memory.
// Define MEM_READ_SLAVE_ERR_EN to answer out-of-range reads with SLVERR; otherwise the index wraps modulo DEPTH.
module mem_read_slave #(
   parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        ARVALID,
   output logic        ARREADY,
   input  logic [63:0] ARADDR,
   output logic        RVALID,
   input  logic        RREADY,
   output logic [63:0] RDATA,
   output logic [1:0]  RRESP,
   input  logic        wr_en,
   input  logic [63:0] wr_addr,
   input  logic [63:0] wr_data
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [63:0] r_addr;
   logic        r_arready;
   logic        r_rvalid;
   logic [63:0] r_rdata;
   logic [1:0]  r_rresp;
   logic [63:0] r_mem [DEPTH];
   logic [63:0] w_rd_addr;
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_wr_idx;
   logic        w_wr_ok;
   logic [63:0] w_rd_data;
   logic [1:0]  w_rd_resp;
   // A zero-latency read enters RESP on the accept edge, before r_addr holds the address.
   assign w_rd_addr = (r_state == IDLE) ? ARADDR : r_addr;
   assign w_rd_idx  = AW'((w_rd_addr - BASE) >> 3);
   assign w_wr_idx  = AW'((wr_addr - BASE) >> 3);
   assign w_wr_ok   = ((wr_addr - BASE) >> 3) < 64'(DEPTH);
`ifdef MEM_READ_SLAVE_ERR_EN
   logic w_rd_ok;
   assign w_rd_ok   = ((w_rd_addr - BASE) >> 3) < 64'(DEPTH);
   assign w_rd_data = w_rd_ok ? r_mem[w_rd_idx] : 64'd0;
   assign w_rd_resp = w_rd_ok ? 2'b00 : 2'b10;
`else
   assign w_rd_data = r_mem[w_rd_idx];
   assign w_rd_resp = 2'b00;
`endif
   always_ff @(posedge ACLK)
      if (wr_en && w_wr_ok) r_mem[w_wr_idx] <= wr_data;
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= 64'd0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 64'd0;
         r_rresp   <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               if (ARVALID && r_arready) begin
                  r_addr    <= ARADDR;
                  r_cnt     <= 4'(LATENCY);
                  r_arready <= 1'b0;
                  if (LATENCY == 0) begin
                     r_state  <= RESP;
                     r_rvalid <= 1'b1;
                     r_rdata  <= w_rd_data;
                     r_rresp  <= w_rd_resp;
                  end else begin
                     r_state <= WAIT;
                  end
               end else begin
                  r_arready <= 1'b1;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state  <= RESP;
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_rd_data;
                  r_rresp  <= w_rd_resp;
               end
            end
            RESP: begin
               if (RREADY) begin
                  r_state   <= IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rdata   <= 64'd0;
                  r_rresp   <= 2'b00;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign ARREADY = r_arready;
   assign RVALID  = r_rvalid;
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;
endmodule

// File: tb/tb_mem_read_slave.sv
// tb_mem_read_slave: directed checks of mem_read_slave with LATENCY=2 (u0) and LATENCY=0 (u1) instances.
module tb_mem_read_slave;
   logic        clk = 1'b0;
   logic        ARESET = 1'b1;
   logic        av [2];
   logic        arr [2];
   logic        rv [2];
   logic [63:0] rdat [2];
   logic [1:0]  rr [2];
   logic [63:0] ARADDR = 64'd0;
   logic        RREADY = 1'b0;
   logic        wr_en = 1'b0;
   logic [63:0] wr_addr = 64'd0;
   logic [63:0] wr_data = 64'd0;
   int total = 0;
   int bad = 0;
   localparam logic [63:0] D0 = 64'h5;
   localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0013;
   localparam logic [63:0] DT = 64'h77;
`ifdef MEM_READ_SLAVE_ERR_EN
   localparam logic [63:0] OOR_D0 = 64'd0;
   localparam logic [63:0] OOR_DT = 64'd0;
   localparam logic [1:0]  OOR_R  = 2'b10;
`else
   localparam logic [63:0] OOR_D0 = D0;
   localparam logic [63:0] OOR_DT = DT;
   localparam logic [1:0]  OOR_R  = 2'b00;
`endif
   always #5 clk = ~clk;
   mem_read_slave #(.LATENCY(2)) u0 (
      .ACLK(clk), .ARESET(ARESET), .ARVALID(av[0]), .ARREADY(arr[0]), .ARADDR(ARADDR),
      .RVALID(rv[0]), .RREADY(RREADY), .RDATA(rdat[0]), .RRESP(rr[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
   mem_read_slave #(.LATENCY(0)) u1 (
      .ACLK(clk), .ARESET(ARESET), .ARVALID(av[1]), .ARREADY(arr[1]), .ARADDR(ARADDR),
      .RVALID(rv[1]), .RREADY(RREADY), .RDATA(rdat[1]), .RRESP(rr[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [63:0] a, input logic [63:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask
   // lat counts cycles from the accept edge to RVALID visible, inclusive of the accept cycle
   task automatic rd(input int d, input logic [63:0] a, input logic [63:0] ed, input logic [1:0] er,
                     input int lat, input int hold, input bit clash);
      int n;
      @(negedge clk);
      ARADDR = a; av[d] = 1'b1; RREADY = (hold == 0);
      n = 0;
      while (!arr[d] && n < 20) begin @(negedge clk); n++; end
      chk("arready_wait", 64'(n < 20), 64'd1);
      @(posedge clk); #1 av[d] = 1'b0;
      n = 1;
      while (!rv[d] && n < 20) begin
         if (clash && n == lat - 1) begin wr_en = 1'b1; wr_addr = a; wr_data = 64'h1; end
         @(posedge clk); #1 wr_en = 1'b0;
         n++;
      end
      chk("latency", 64'(n), 64'(lat));
      chk("rdata", rdat[d], ed);
      chk("rresp", 64'(rr[d]), 64'(er));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         av[d] = 1'b1; ARADDR = 64'h8000_0018;
         chk("hold_rvalid", 64'(rv[d]), 64'd1);
         chk("hold_rdata", rdat[d], ed);
         chk("hold_rresp", 64'(rr[d]), 64'(er));
         chk("hold_arready", 64'(arr[d]), 64'd0);
      end
      @(negedge clk);
      av[d] = 1'b0; ARADDR = a; RREADY = 1'b1;
      @(posedge clk); #1;
      chk("post_rvalid", 64'(rv[d]), 64'd0);
      chk("post_arready", 64'(arr[d]), 64'd1);
      chk("idle_rdata", rdat[d], 64'd0);
      if (hold > 0)
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ignored_ar", 64'(rv[d]), 64'd0);
         end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      av[0] = 1'b0; av[1] = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_arready", 64'(arr[d]), 64'd0);
         chk("rst_rvalid", 64'(rv[d]), 64'd0);
         chk("rst_rdata", rdat[d], 64'd0);
         chk("rst_rresp", 64'(rr[d]), 64'd0);
      end
      ARESET = 1'b0;
      #1 chk("arready_before_edge", 64'(arr[0]), 64'd0);
      @(posedge clk); #1 chk("arready_after_edge", 64'(arr[0]), 64'd1);
      wr(64'h8000_0000, D0);
      wr(64'h8000_0008, D1);
      wr(64'h8000_0010, D2);
      wr(64'h8000_1FF8, DT);
      wr(64'h8000_2000, 64'hBAD);
      wr(64'h7FFF_FFF8, 64'hBAD2);
      rd(0, 64'h8000_0010, D2, 2'b00, 3, 0, 1'b0);
      rd(0, 64'h8000_0008, D1, 2'b00, 3, 5, 1'b0);
      rd(0, 64'h8000_000C, D1, 2'b00, 3, 0, 1'b0);
      rd(0, 64'h8000_1FF8, DT, 2'b00, 3, 0, 1'b0);
      rd(0, 64'h8000_2000, OOR_D0, OOR_R, 3, 0, 1'b0);
      rd(0, 64'h7FFF_FFF8, OOR_DT, OOR_R, 3, 0, 1'b0);
      rd(1, 64'h8000_0008, D1, 2'b00, 1, 0, 1'b0);
      rd(1, 64'h8000_0010, D2, 2'b00, 1, 2, 1'b0);
      @(negedge clk);
      ARADDR = 64'h8000_0010; av[0] = 1'b1; RREADY = 1'b1;
      @(posedge clk); #1 av[0] = 1'b0;
      chk("wait_arready", 64'(arr[0]), 64'd0);
      #2 ARESET = 1'b1;
      #1;
      chk("rst_wait_rvalid", 64'(rv[0]), 64'd0);
      chk("rst_wait_arready", 64'(arr[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      ARESET = 1'b0;
      #1 chk("rel_arready_pre", 64'(arr[0]), 64'd0);
      @(posedge clk); #1 chk("rel_arready_post", 64'(arr[0]), 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("aborted_rvalid", 64'(rv[0]), 64'd0);
      end
      @(negedge clk);
      ARADDR = 64'h8000_0010; av[0] = 1'b1; RREADY = 1'b0;
      @(posedge clk); #1 av[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("resp_before_rst", 64'(rv[0]), 64'd1);
      ARESET = 1'b1;
      #1;
      chk("rst_resp_rvalid", 64'(rv[0]), 64'd0);
      chk("rst_resp_rdata", rdat[0], 64'd0);
      @(negedge clk);
      ARESET = 1'b0; RREADY = 1'b1;
      rd(0, 64'h8000_0010, D2, 2'b00, 3, 0, 1'b0);
      rd(0, 64'h8000_0000, D0, 2'b00, 3, 0, 1'b1);
      rd(0, 64'h8000_0000, 64'h1, 2'b00, 3, 0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
